fb_rect_fill: RTL and testbench

FB_RECT_FILL -- requirements
Module: fb_rect_fill

---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_rect_clip.sv | 37 +++
 rtl/fb_rect_fill.sv | 164 ++++++++++++++++
 tb/tb_fb_rect_fill.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the rectangle-fill engine.
//   H_RES, V_RES : default framebuffer size in pixels
//   COORD_W      : default width of every coordinate / size field
//   fb_fill_state_t : fill controller states
package fb_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COORD_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_FILL      = 2'd2,
    ST_DONE      = 2'd3
  } fb_fill_state_t;

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational clip / empty detection for a rectangle command.
//   x0, y0  : top-left corner
//   w, h    : size in pixels
//   x_end   : min(x0 + w, H_RES), exclusive right edge
//   y_end   : min(y0 + h, V_RES), exclusive bottom edge
//   empty   : rectangle covers no on-screen pixel
module fb_rect_clip #(
  parameter int H_RES   = fb_pkg::H_RES,
  parameter int V_RES   = fb_pkg::V_RES,
  parameter int COORD_W = fb_pkg::COORD_W
) (
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  output logic [COORD_W:0]   x_end,
  output logic [COORD_W:0]   y_end,
  output logic               empty
);

  localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_RES);
  localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_RES);

  logic [COORD_W:0] x_sum;
  logic [COORD_W:0] y_sum;

  // One extra bit on the sums so a corner near the top of the coordinate
  // range plus a large size cannot wrap back on screen.
  always_comb begin
    x_sum = {1'b0, x0} + {1'b0, w};
    y_sum = {1'b0, y0} + {1'b0, h};
    x_end = (x_sum > H_LIM) ? H_LIM : x_sum;
    y_end = (y_sum > V_LIM) ? V_LIM : y_sum;
    empty = (w == '0) || (h == '0) || ({1'b0, x0} >= H_LIM) || ({1'b0, y0} >= V_LIM);
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: accepts one command at a time, clips it to the
// framebuffer and emits one pixel write per cycle in raster order.
//   clk50, reset_n         : clock, synchronous active-low reset
//   cmd_valid / cmd_ready  : command handshake (ready only in IDLE)
//   cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, cmd_sync : command fields
//   frame_start            : field-start pulse, releases a synced command
//   abort                  : stop the current command early
//   x, y, pixel_color, pixel_write : framebuffer write port
//   busy                   : a command is held
//   done                   : one-cycle completion pulse
module fb_rect_fill #(
  parameter int H_RES   = fb_pkg::H_RES,
  parameter int V_RES   = fb_pkg::V_RES,
  parameter int COORD_W = fb_pkg::COORD_W
) (
  input  logic               clk50,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic               cmd_color,
  input  logic               cmd_sync,
  input  logic               frame_start,
  input  logic               abort,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               pixel_color,
  output logic               pixel_write,
  output logic               busy,
  output logic               done
);

  import fb_pkg::*;

  localparam logic [COORD_W:0] ONE_W = (COORD_W+1)'(1);

  fb_fill_state_t   state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
  logic [COORD_W:0]   x_end_q, x_end_d, y_end_q, y_end_d;
  logic               color_q, color_d;

  logic [COORD_W:0]   clip_x_end, clip_y_end;
  logic               clip_empty;
  logic               accept, x_last, y_last;

  fb_rect_clip #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .COORD_W(COORD_W)
  ) u_clip (
    .x0   (cmd_x0),
    .y0   (cmd_y0),
    .w    (cmd_w),
    .h    (cmd_h),
    .x_end(clip_x_end),
    .y_end(clip_y_end),
    .empty(clip_empty)
  );

  assign accept = cmd_valid && (state_q == ST_IDLE);
  assign x_last = (({1'b0, x_q} + ONE_W) == x_end_q);
  assign y_last = (({1'b0, y_q} + ONE_W) == y_end_q);

  // NOTE: every variable gets its hold value first so no path through the
  // case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    color_d = color_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          x_end_d = clip_x_end;
          y_end_d = clip_y_end;
          color_d = cmd_color;
          if (clip_empty) begin
            state_d = ST_DONE;
          end else if (cmd_sync) begin
            state_d = ST_WAIT_SYNC;
          end else begin
            // Counters load on entry to FILL only, so x/y keep showing the
            // previous position while a command waits or is empty.
            state_d = ST_FILL;
            x_d     = cmd_x0;
            y_d     = cmd_y0;
          end
        end
      end

      ST_WAIT_SYNC: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (frame_start) begin
          state_d = ST_FILL;
          x_d     = x0_q;
          y_d     = y0_q;
        end
      end

      ST_FILL: begin
        // The pixel on this cycle is written regardless; abort only stops
        // the scan from advancing.
        if (abort || (x_last && y_last)) begin
          state_d = ST_DONE;
        end else if (x_last) begin
          x_d = x0_q;
          y_d = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      color_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      color_q <= color_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pixel_color = color_q;
  assign pixel_write = (state_q == ST_FILL);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  // Gated by reset_n so no command can be offered while reset is held.
  assign cmd_ready   = reset_n && (state_q == ST_IDLE);

endmodule

// File: tb/tb_fb_rect_fill.sv
module tb_fb_rect_fill;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int CW = 11;

  logic          clk50 = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_w = '0, cmd_h = '0;
  logic          cmd_color = 1'b0, cmd_sync = 1'b0;
  logic          frame_start = 1'b0, abort = 1'b0;
  logic [CW-1:0] x, y;
  logic          pixel_color, pixel_write, busy, done;

  int checks = 0;
  int errors = 0;

  // Observation of one command, recorded by collect(); cycle 0 is the
  // acceptance cycle.
  int obs_x[$], obs_y[$], obs_col[$], obs_cyc[$], done_cyc[$];
  bit ready_next, timed_out;
  int hold_x, hold_y;

  fb_rect_fill #(.H_RES(H), .V_RES(V), .COORD_W(CW)) dut (
    .clk50(clk50), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_sync(cmd_sync),
    .frame_start(frame_start), .abort(abort),
    .x(x), .y(y), .pixel_color(pixel_color), .pixel_write(pixel_write),
    .busy(busy), .done(done)
  );

  always #10 clk50 = ~clk50;

  initial begin
    #50ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Present a command during cycle 0; returns at the middle of cycle 1.
  task automatic drive_cmd(input int x0, y0, w, h, input bit col, sync, fs0, ab0);
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_before_cmd: got %b, required 1", cmd_ready);
    end
    checks++;
    cmd_x0 = CW'(x0); cmd_y0 = CW'(y0); cmd_w = CW'(w); cmd_h = CW'(h);
    cmd_color = col; cmd_sync = sync; frame_start = fs0; abort = ab0;
    cmd_valid = 1'b1;
    @(negedge clk50);
    cmd_valid = 1'b0; frame_start = 1'b0; abort = 1'b0;
  endtask

  // Record writes and done pulses from cycle 1 until the cycle after done.
  task automatic collect(input int budget, input int ab_cyc, input int fs_cyc);
    obs_x.delete(); obs_y.delete(); obs_col.delete(); obs_cyc.delete();
    done_cyc.delete();
    timed_out = 1'b1; ready_next = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      abort = (c == ab_cyc);
      frame_start = (c == fs_cyc);
      if (pixel_write) begin
        obs_x.push_back(int'(x)); obs_y.push_back(int'(y));
        obs_col.push_back(int'(pixel_color)); obs_cyc.push_back(c);
      end
      if (done) done_cyc.push_back(c);
      if (done_cyc.size() > 0 && c == done_cyc[0] + 1) begin
        ready_next = cmd_ready; hold_x = int'(x); hold_y = int'(y);
        timed_out = 1'b0;
        break;
      end
      @(negedge clk50);
    end
    abort = 1'b0; frame_start = 1'b0;
  endtask

  // Reference: what the fill must produce, from plain rectangle arithmetic.
  task automatic model(input int x0, y0, w, h, input bit sync, input int fs, ab,
                       output int cw, output int n_exp, output int start, output int done_exp);
    int xe, ye, total;
    xe = (x0 + w < H) ? x0 + w : H;
    ye = (y0 + h < V) ? y0 + h : V;
    if (w == 0 || h == 0 || x0 >= H || y0 >= V) begin
      cw = 1; n_exp = 0; start = 1; done_exp = 1;
      return;
    end
    cw = xe - x0;
    total = cw * (ye - y0);
    start = sync ? fs + 1 : 1;
    if (ab >= 1 && ab < start) begin
      n_exp = 0; done_exp = ab + 1;
    end else if (ab >= start && ab < start + total) begin
      n_exp = ab - start + 1; done_exp = ab + 1;
    end else begin
      n_exp = total; done_exp = start + total;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk50);
    if ({x, y} !== '0) begin
      errors++; $display("FAIL reset_xy: got x=%0d y=%0d, required 0 0", x, y);
    end
    checks++;
    if ({pixel_write, pixel_color, done, busy, cmd_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got wr=%b col=%b done=%b busy=%b rdy=%b, required all 0",
               pixel_write, pixel_color, done, busy, cmd_ready);
    end
    checks++;
    reset_n = 1'b1;
    @(negedge clk50);
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b, required 1", cmd_ready);
    end
    checks++;
  endtask

  task automatic test_plain();
    int ex[6] = '{10, 11, 12, 10, 11, 12};
    int ey[6] = '{20, 20, 20, 21, 21, 21};
    drive_cmd(10, 20, 3, 2, 1'b1, 1'b0, 1'b0, 1'b1);  // abort in IDLE is ignored
    collect(50, 0, 0);
    if (obs_x.size() != 6) begin
      errors++; $display("FAIL plain_count: got %0d writes, required 6", obs_x.size());
    end
    checks++;
    for (int i = 0; i < 6 && i < obs_x.size(); i++) begin
      if (obs_x[i] != ex[i] || obs_y[i] != ey[i] || obs_cyc[i] != i + 1 || obs_col[i] != 1) begin
        errors++;
        $display("FAIL plain_pixel%0d: got (%0d,%0d) col %0d cycle %0d, required (%0d,%0d) col 1 cycle %0d",
                 i, obs_x[i], obs_y[i], obs_col[i], obs_cyc[i], ex[i], ey[i], i + 1);
      end
      checks++;
    end
    if (timed_out || done_cyc.size() != 1 || done_cyc[0] != 7 || ready_next !== 1'b1) begin
      errors++;
      $display("FAIL plain_done: got done pulses %0d first %0d ready %b, required 1 pulse at 7 ready 1",
               done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, ready_next);
    end
    checks++;
  endtask

  task automatic test_clip();
    drive_cmd(638, 479, 5, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    collect(50, 0, 0);
    if (obs_x.size() != 2 || obs_x[0] != 638 || obs_x[1] != 639 || obs_y[0] != 479 || obs_y[1] != 479) begin
      errors++;
      $display("FAIL clip_pixels: got %0d writes first (%0d,%0d), required (638,479),(639,479)",
               obs_x.size(), obs_x.size() ? obs_x[0] : -1, obs_y.size() ? obs_y[0] : -1);
    end
    checks++;
    if (timed_out || done_cyc.size() != 1 || done_cyc[0] != 3) begin
      errors++; $display("FAIL clip_done: got %0d pulses, required one at cycle 3", done_cyc.size());
    end
    checks++;
  endtask

  task automatic test_empty();
    drive_cmd(5, 5, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    collect(20, 0, 0);
    if (obs_x.size() != 0 || timed_out || done_cyc.size() != 1 || done_cyc[0] != 1) begin
      errors++;
      $display("FAIL empty: got %0d writes %0d done pulses, required 0 writes, done at cycle 1",
               obs_x.size(), done_cyc.size());
    end
    checks++;
  endtask

  task automatic test_sync();
    drive_cmd(5, 7, 2, 1, 1'b1, 1'b1, 1'b1, 1'b0);  // frame_start on acceptance cycle
    collect(100, 0, 50);
    if (obs_x.size() != 2 || obs_cyc[0] != 51 || obs_x[0] != 5 || obs_y[0] != 7) begin
      errors++;
      $display("FAIL sync_first: got %0d writes first at cycle %0d, required (5,7) at cycle 51",
               obs_x.size(), obs_cyc.size() ? obs_cyc[0] : -1);
    end
    checks++;
    if (timed_out || done_cyc.size() != 1 || done_cyc[0] != 53) begin
      errors++; $display("FAIL sync_done: got %0d pulses, required one at cycle 53", done_cyc.size());
    end
    checks++;
  endtask

  task automatic test_abort();
    drive_cmd(0, 0, H, V, 1'b1, 1'b0, 1'b0, 1'b0);
    collect(50, 3, 0);
    if (obs_x.size() != 3 || obs_x[2] != 2 || obs_y[2] != 0 || obs_cyc[2] != 3) begin
      errors++;
      $display("FAIL abort_writes: got %0d writes, required 3 ending (2,0) at cycle 3", obs_x.size());
    end
    checks++;
    if (timed_out || done_cyc.size() != 1 || done_cyc[0] != 4) begin
      errors++; $display("FAIL abort_done: got %0d pulses, required one at cycle 4", done_cyc.size());
    end
    checks++;
  endtask

  task automatic test_reset_mid_fill();
    int early_done = 0;
    drive_cmd(0, 0, H, V, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c < 100; c++) begin
      if (done) early_done++;
      @(negedge clk50);
    end
    reset_n = 1'b0;                 // low across the edge ending cycle 100
    @(negedge clk50);               // cycle 101
    if (pixel_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || early_done != 0) begin
      errors++;
      $display("FAIL reset_mid: got wr=%b busy=%b done=%b early_done=%0d, required 0 0 0 0",
               pixel_write, busy, done, early_done);
    end
    checks++;
    if ({x, y} !== '0 || pixel_color !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: got x=%0d y=%0d col=%b rdy=%b, required 0 0 0 0",
               x, y, pixel_color, cmd_ready);
    end
    checks++;
    @(negedge clk50);
    reset_n = 1'b1;
    @(negedge clk50);
    if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: got rdy=%b done=%b busy=%b, required 1 0 0", cmd_ready, done, busy);
    end
    checks++;
  endtask

  task automatic test_random(input int n_cmds);
    int x0, y0, w, h, fs, ab, cw, n_exp, start, done_exp;
    bit col, sync;
    for (int k = 0; k < n_cmds; k++) begin
      x0 = ($urandom_range(0, 2) == 0) ? H - 1 - $urandom_range(0, 6) + $urandom_range(0, 3)
                                       : $urandom_range(0, H - 1);
      y0 = ($urandom_range(0, 2) == 0) ? V - 1 - $urandom_range(0, 4) + $urandom_range(0, 2)
                                       : $urandom_range(0, V - 1);
      w = $urandom_range(0, 10);
      h = $urandom_range(0, 5);
      col = 1'($urandom_range(0, 1));
      sync = ($urandom_range(0, 2) == 0);
      fs = sync ? $urandom_range(1, 12) : 0;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      model(x0, y0, w, h, sync, fs, ab, cw, n_exp, start, done_exp);
      drive_cmd(x0, y0, w, h, col, sync, 1'b0, 1'b0);
      collect(200, ab, fs);
      if (timed_out || done_cyc.size() != 1 || done_cyc[0] != done_exp || ready_next !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_done: got %0d pulses first %0d ready %b, required one at %0d ready 1",
                 k, done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, ready_next, done_exp);
      end
      checks++;
      if (obs_x.size() != n_exp) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d writes, required %0d (cmd %0d,%0d %0dx%0d)",
                 k, obs_x.size(), n_exp, x0, y0, w, h);
      end
      checks++;
      for (int i = 0; i < n_exp && i < obs_x.size(); i++) begin
        if (obs_x[i] != x0 + i % cw || obs_y[i] != y0 + i / cw ||
            obs_cyc[i] != start + i || obs_col[i] != int'(col)) begin
          errors++;
          $display("FAIL rand%0d_pix%0d: got (%0d,%0d) col %0d cycle %0d, required (%0d,%0d) col %0d cycle %0d",
                   k, i, obs_x[i], obs_y[i], obs_col[i], obs_cyc[i],
                   x0 + i % cw, y0 + i / cw, col, start + i);
        end
        checks++;
      end
      if (n_exp > 0) begin
        if (hold_x != x0 + (n_exp - 1) % cw || hold_y != y0 + (n_exp - 1) / cw) begin
          errors++;
          $display("FAIL rand%0d_hold: got (%0d,%0d), required last written (%0d,%0d)",
                   k, hold_x, hold_y, x0 + (n_exp - 1) % cw, y0 + (n_exp - 1) / cw);
        end
        checks++;
      end
    end
  endtask

  initial begin
    @(negedge clk50);
    test_reset();
    test_plain();
    test_clip();
    test_empty();
    test_sync();
    test_abort();
    test_reset_mid_fill();
    test_random(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
